// File: rtl/sysid_check_arbiter.sv
// Verifies the system-ID slave contents after reset (and optionally on a timer),
// then shares the slave between two Avalon-MM read masters with round-robin arbitration.
module sysid_check_arbiter #(
    parameter logic [31:0] EXPECTED_ID    = 32'd29,
    parameter logic [31:0] EXPECTED_TS    = 32'd1718188374,
    parameter int unsigned RECHECK_PERIOD = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        sysid_address,
    input  logic [31:0] sysid_readdata,
    input  logic        m0_read,
    input  logic        m0_address,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    output logic        m0_readdatavalid,
    input  logic        m1_read,
    input  logic        m1_address,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        m1_readdatavalid,
    input  logic        irq_clear,
    output logic        check_done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        mismatch_irq
);

    localparam logic [1:0] CHK_ID = 2'd0;
    localparam logic [1:0] CHK_TS = 2'd1;
    localparam logic [1:0] IDLE   = 2'd2;

    localparam logic        RECHECK_EN  = (RECHECK_PERIOD != 0);
    localparam logic [31:0] PERIOD_LAST = RECHECK_PERIOD - 32'd1;

    logic [1:0]  state_q, state_d;
    logic        lastGrant_q, lastGrant_d;
    logic        pending_q, pending_d;
    logic        started_q, started_d;
    logic [31:0] counter_q, counter_d;
    logic        idOk_q, idOk_d;
    logic        tsOk_q, tsOk_d;
    logic        checkDone_q, checkDone_d;
    logic        irq_q, irq_d;
    logic [31:0] m0Data_q, m0Data_d;
    logic [31:0] m1Data_q, m1Data_d;
    logic        m0Valid_q, m0Valid_d;
    logic        m1Valid_q, m1Valid_d;

    logic canGrant;
    logic grant0;
    logic grant1;
    logic wrap;
    logic irqSet;

    // lastGrant_q = 1 means m1 was served last, so m0 wins the next tie.
    always_comb begin
        canGrant = reset_n && (state_q == IDLE) && !pending_q;
        grant0   = canGrant && m0_read && (!m1_read || lastGrant_q);
        grant1   = canGrant && m1_read && !grant0;
        wrap     = RECHECK_EN && started_q && (counter_q == PERIOD_LAST);
    end

    assign m0_waitrequest = m0_read && !grant0;
    assign m1_waitrequest = m1_read && !grant1;

    always_comb begin
        state_d       = state_q;
        lastGrant_d   = lastGrant_q;
        started_d     = started_q;
        counter_d     = counter_q;
        idOk_d        = idOk_q;
        tsOk_d        = tsOk_q;
        checkDone_d   = checkDone_q;
        m0Data_d      = m0Data_q;
        m1Data_d      = m1Data_q;
        m0Valid_d     = 1'b0;
        m1Valid_d     = 1'b0;
        irqSet        = 1'b0;
        sysid_address = 1'b0;

        case (state_q)
            CHK_ID: begin
                sysid_address = 1'b0;
                idOk_d        = (sysid_readdata == EXPECTED_ID);
                state_d       = CHK_TS;
            end
            CHK_TS: begin
                sysid_address = 1'b1;
                tsOk_d        = (sysid_readdata == EXPECTED_TS);
                checkDone_d   = 1'b1;
                irqSet        = !idOk_q || (sysid_readdata != EXPECTED_TS);
                started_d     = 1'b1;
                state_d       = IDLE;
            end
            IDLE: begin
                if (pending_q) begin
                    state_d = CHK_ID;
                end else begin
                    if (grant0) begin
                        sysid_address = m0_address;
                        m0Data_d      = sysid_readdata;
                        m0Valid_d     = 1'b1;
                        lastGrant_d   = 1'b0;
                    end else if (grant1) begin
                        sysid_address = m1_address;
                        m1Data_d      = sysid_readdata;
                        m1Valid_d     = 1'b1;
                        lastGrant_d   = 1'b1;
                    end
                    // A wrap seen in IDLE starts the recheck right away, so masters lose only the two check cycles.
                    if (wrap) begin
                        state_d = CHK_ID;
                    end
                end
            end
            default: state_d = CHK_ID;
        endcase

        if (RECHECK_EN && started_q) begin
            counter_d = wrap ? 32'd0 : counter_q + 32'd1;
        end

        // A wrap during a check is remembered until the next IDLE cycle.
        if ((state_q == IDLE) && (state_d == CHK_ID)) begin
            pending_d = 1'b0;
        end else if (wrap) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end

        if (irqSet) begin
            irq_d = 1'b1;
        end else if (irq_clear) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= CHK_ID;
            lastGrant_q <= 1'b1;
            pending_q   <= 1'b0;
            started_q   <= 1'b0;
            counter_q   <= 32'd0;
            idOk_q      <= 1'b0;
            tsOk_q      <= 1'b0;
            checkDone_q <= 1'b0;
            irq_q       <= 1'b0;
            m0Data_q    <= 32'd0;
            m1Data_q    <= 32'd0;
            m0Valid_q   <= 1'b0;
            m1Valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            pending_q   <= pending_d;
            started_q   <= started_d;
            counter_q   <= counter_d;
            idOk_q      <= idOk_d;
            tsOk_q      <= tsOk_d;
            checkDone_q <= checkDone_d;
            irq_q       <= irq_d;
            m0Data_q    <= m0Data_d;
            m1Data_q    <= m1Data_d;
            m0Valid_q   <= m0Valid_d;
            m1Valid_q   <= m1Valid_d;
        end
    end

    assign m0_readdata      = m0Data_q;
    assign m1_readdata      = m1Data_q;
    assign m0_readdatavalid = m0Valid_q;
    assign m1_readdatavalid = m1Valid_q;
    assign check_done       = checkDone_q;
    assign id_ok            = idOk_q;
    assign ts_ok            = tsOk_q;
    assign mismatch_irq     = irq_q;

endmodule

// File: tb/tb_sysid_check_arbiter.sv
// Bench for sysid_check_arbiter: one instance without recheck (dutA) and one with an
// 8-cycle recheck period (dutB), each attached to a small behavioural sysid slave.
module tb_sysid_check_arbiter;

    localparam logic [31:0] ID_GOOD = 32'd29;
    localparam logic [31:0] TS_GOOD = 32'd1718188374;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetN;
    logic        sysidAddrA, sysidAddrB;
    logic [31:0] sysidDataA, sysidDataB, idA, tsA, idB, tsB;
    logic        m0ReadA, m0AddrA, m0WaitA, m0ValidA, m1ReadA, m1AddrA, m1WaitA, m1ValidA;
    logic [31:0] m0DataA, m1DataA, m0DataB, m1DataB;
    logic        m0ReadB, m0AddrB, m0WaitB, m0ValidB, m1ReadB, m1AddrB, m1WaitB, m1ValidB;
    logic        irqClearA, checkDoneA, idOkA, tsOkA, irqA;
    logic        irqClearB, checkDoneB, idOkB, tsOkB, irqB;

    int compared = 0;
    int mismatched = 0;

    // Word 0 is the system ID, word 1 the timestamp; readdata follows address combinationally.
    assign sysidDataA = sysidAddrA ? tsA : idA;
    assign sysidDataB = sysidAddrB ? tsB : idB;

    sysid_check_arbiter dutA (
        .clock(clock), .reset_n(resetN), .sysid_address(sysidAddrA), .sysid_readdata(sysidDataA),
        .m0_read(m0ReadA), .m0_address(m0AddrA), .m0_waitrequest(m0WaitA),
        .m0_readdata(m0DataA), .m0_readdatavalid(m0ValidA),
        .m1_read(m1ReadA), .m1_address(m1AddrA), .m1_waitrequest(m1WaitA),
        .m1_readdata(m1DataA), .m1_readdatavalid(m1ValidA),
        .irq_clear(irqClearA), .check_done(checkDoneA), .id_ok(idOkA), .ts_ok(tsOkA),
        .mismatch_irq(irqA)
    );

    sysid_check_arbiter #(.RECHECK_PERIOD(8)) dutB (
        .clock(clock), .reset_n(resetN), .sysid_address(sysidAddrB), .sysid_readdata(sysidDataB),
        .m0_read(m0ReadB), .m0_address(m0AddrB), .m0_waitrequest(m0WaitB),
        .m0_readdata(m0DataB), .m0_readdatavalid(m0ValidB),
        .m1_read(m1ReadB), .m1_address(m1AddrB), .m1_waitrequest(m1WaitB),
        .m1_readdata(m1DataB), .m1_readdatavalid(m1ValidB),
        .irq_clear(irqClearB), .check_done(checkDoneB), .id_ok(idOkB), .ts_ok(tsOkB),
        .mismatch_irq(irqB)
    );

    task step;
        @(posedge clock);
        #1;
    endtask

    // Holds reset for two edges and releases it; the check starts on the following edge.
    task holdReset;
        resetN = 1'b0;
        step;
        step;
        resetN = 1'b1;
    endtask

    task resetToIdle;
        holdReset;
        step;
        step;
    endtask

    task test_reset;
        idA = ID_GOOD; tsA = TS_GOOD; idB = ID_GOOD; tsB = TS_GOOD;
        m0ReadA = 1'b1; m0AddrA = 1'b0; m1ReadA = 1'b0; m1AddrA = 1'b0; irqClearA = 1'b0;
        m0ReadB = 1'b0; m0AddrB = 1'b0; m1ReadB = 1'b0; m1AddrB = 1'b0; irqClearB = 1'b0;
        resetN = 1'b0;
        step;
        step;
        compared++; if (m0WaitA !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_wait: got %b expected 1", m0WaitA); end
        compared++; if (m0ValidA !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", m0ValidA); end
        compared++; if (m0DataA !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_data: got %0h expected 0", m0DataA); end
        compared++; if ({checkDoneA, idOkA, tsOkA, irqA} !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_flags: got %b expected 0000", {checkDoneA, idOkA, tsOkA, irqA}); end
        m0ReadA = 1'b0;
        resetN = 1'b1;
        #1;
        compared++; if (sysidAddrA !== 1'b0) begin mismatched++; $display("[TB] FAIL chk_addr0: got %b expected 0", sysidAddrA); end
        step;
        compared++; if (sysidAddrA !== 1'b1) begin mismatched++; $display("[TB] FAIL chk_addr1: got %b expected 1", sysidAddrA); end
        compared++; if (checkDoneA !== 1'b0) begin mismatched++; $display("[TB] FAIL done_early: got %b expected 0", checkDoneA); end
        step;
        compared++; if ({checkDoneA, idOkA, tsOkA, irqA} !== 4'b1110) begin mismatched++; $display("[TB] FAIL check_pass: got %b expected 1110", {checkDoneA, idOkA, tsOkA, irqA}); end
    endtask

    task test_id_mismatch;
        idA = 32'd30;
        holdReset;
        step;
        step;
        compared++; if ({checkDoneA, idOkA, tsOkA, irqA} !== 4'b1011) begin mismatched++; $display("[TB] FAIL id_mismatch: got %b expected 1011", {checkDoneA, idOkA, tsOkA, irqA}); end
        irqClearA = 1'b1;
        step;
        irqClearA = 1'b0;
        compared++; if (irqA !== 1'b0) begin mismatched++; $display("[TB] FAIL irq_clear: got %b expected 0", irqA); end
        step;
        compared++; if (irqA !== 1'b0) begin mismatched++; $display("[TB] FAIL irq_stays_clear: got %b expected 0", irqA); end
        holdReset;
        step;
        irqClearA = 1'b1;
        step;
        irqClearA = 1'b0;
        compared++; if (irqA !== 1'b1) begin mismatched++; $display("[TB] FAIL irq_set_wins: got %b expected 1", irqA); end
        idA = ID_GOOD;
    endtask

    task test_single_read;
        resetToIdle;
        m0ReadA = 1'b1;
        m0AddrA = 1'b1;
        #1;
        compared++; if (m0WaitA !== 1'b0) begin mismatched++; $display("[TB] FAIL single_wait: got %b expected 0", m0WaitA); end
        compared++; if (sysidAddrA !== 1'b1) begin mismatched++; $display("[TB] FAIL single_addr: got %b expected 1", sysidAddrA); end
        compared++; if (m1WaitA !== 1'b0) begin mismatched++; $display("[TB] FAIL single_m1_wait: got %b expected 0", m1WaitA); end
        step;
        m0ReadA = 1'b0;
        compared++; if (m0ValidA !== 1'b1) begin mismatched++; $display("[TB] FAIL single_valid: got %b expected 1", m0ValidA); end
        compared++; if (m0DataA !== TS_GOOD) begin mismatched++; $display("[TB] FAIL single_data: got %0h expected %0h", m0DataA, TS_GOOD); end
        compared++; if ({m1ValidA, m1DataA} !== 33'd0) begin mismatched++; $display("[TB] FAIL single_m1_quiet: got %0h expected 0", {m1ValidA, m1DataA}); end
        step;
        compared++; if (m0ValidA !== 1'b0) begin mismatched++; $display("[TB] FAIL single_pulse_len: got %b expected 0", m0ValidA); end
        compared++; if (m0DataA !== TS_GOOD) begin mismatched++; $display("[TB] FAIL single_hold: got %0h expected %0h", m0DataA, TS_GOOD); end
    endtask

    task test_back_to_back;
        int lastG;
        int prevG;
        int g;
        int v0;
        int v1;
        resetToIdle;
        lastG = 1; prevG = -1; v0 = 0; v1 = 0;
        m0ReadA = 1'b1; m0AddrA = 1'b0;
        m1ReadA = 1'b1; m1AddrA = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin
                m0ReadA = 1'b0;
                m1ReadA = 1'b0;
            end
            #1;
            compared++; if (m0ValidA !== (prevG == 0)) begin mismatched++; $display("[TB] FAIL b2b_valid0[%0d]: got %b expected %b", i, m0ValidA, prevG == 0); end
            compared++; if (m1ValidA !== (prevG == 1)) begin mismatched++; $display("[TB] FAIL b2b_valid1[%0d]: got %b expected %b", i, m1ValidA, prevG == 1); end
            if (prevG == 0) begin
                compared++; if (m0DataA !== ID_GOOD) begin mismatched++; $display("[TB] FAIL b2b_data0[%0d]: got %0h expected %0h", i, m0DataA, ID_GOOD); end
            end
            if (prevG == 1) begin
                compared++; if (m1DataA !== TS_GOOD) begin mismatched++; $display("[TB] FAIL b2b_data1[%0d]: got %0h expected %0h", i, m1DataA, TS_GOOD); end
            end
            v0 += int'(m0ValidA);
            v1 += int'(m1ValidA);
            if (i < 6) begin
                g = (lastG == 0) ? 1 : 0;
                compared++; if (m0WaitA !== (g != 0)) begin mismatched++; $display("[TB] FAIL b2b_wait0[%0d]: got %b expected %b", i, m0WaitA, g != 0); end
                compared++; if (m1WaitA !== (g != 1)) begin mismatched++; $display("[TB] FAIL b2b_wait1[%0d]: got %b expected %b", i, m1WaitA, g != 1); end
                lastG = g;
                prevG = g;
            end else begin
                prevG = -1;
            end
            step;
        end
        compared++; if (v0 != 3 || v1 != 3) begin mismatched++; $display("[TB] FAIL b2b_counts: got %0d/%0d expected 3/3", v0, v1); end
    endtask

    task test_random;
        int lastG;
        int g;
        logic r0, r1, a0, a1, expV0, expV1, expAddr;
        logic [31:0] expD0, expD1, word;
        resetToIdle;
        lastG = 1; expV0 = 1'b0; expV1 = 1'b0; expD0 = 32'd0; expD1 = 32'd0;
        for (int i = 0; i < 60; i++) begin
            r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1));
            a0 = 1'($urandom_range(0, 1)); a1 = 1'($urandom_range(0, 1));
            idA = $urandom; tsA = $urandom;
            m0ReadA = r0; m0AddrA = a0; m1ReadA = r1; m1AddrA = a1;
            #1;
            if (r0 && r1) g = (lastG == 0) ? 1 : 0;
            else if (r0)  g = 0;
            else if (r1)  g = 1;
            else          g = -1;
            compared++; if (m0WaitA !== (r0 && g != 0)) begin mismatched++; $display("[TB] FAIL rnd_wait0[%0d]: got %b expected %b", i, m0WaitA, r0 && g != 0); end
            compared++; if (m1WaitA !== (r1 && g != 1)) begin mismatched++; $display("[TB] FAIL rnd_wait1[%0d]: got %b expected %b", i, m1WaitA, r1 && g != 1); end
            compared++; if ({m0ValidA, m0DataA} !== {expV0, expD0}) begin mismatched++; $display("[TB] FAIL rnd_m0[%0d]: got %b/%0h expected %b/%0h", i, m0ValidA, m0DataA, expV0, expD0); end
            compared++; if ({m1ValidA, m1DataA} !== {expV1, expD1}) begin mismatched++; $display("[TB] FAIL rnd_m1[%0d]: got %b/%0h expected %b/%0h", i, m1ValidA, m1DataA, expV1, expD1); end
            if (g >= 0) begin
                expAddr = (g == 0) ? a0 : a1;
                compared++; if (sysidAddrA !== expAddr) begin mismatched++; $display("[TB] FAIL rnd_addr[%0d]: got %b expected %b", i, sysidAddrA, expAddr); end
                word = expAddr ? tsA : idA;
                lastG = g;
            end else begin
                word = 32'd0;
            end
            expV0 = (g == 0);
            expV1 = (g == 1);
            if (g == 0) expD0 = word;
            if (g == 1) expD1 = word;
            step;
        end
        m0ReadA = 1'b0; m1ReadA = 1'b0;
        idA = ID_GOOD; tsA = TS_GOOD;
    endtask

    task test_reset_mid_grant;
        m1ReadA = 1'b1;
        m1AddrA = 1'b0;
        step;
        m1AddrA = 1'b1;
        resetN = 1'b0;
        #1;
        compared++; if ({m1ValidA, m1DataA} !== {1'b1, ID_GOOD}) begin mismatched++; $display("[TB] FAIL mid_prior_read: got %b/%0h expected 1/%0h", m1ValidA, m1DataA, ID_GOOD); end
        compared++; if (m1WaitA !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_wait_in_reset: got %b expected 1", m1WaitA); end
        step;
        compared++; if ({m1ValidA, m1DataA} !== 33'd0) begin mismatched++; $display("[TB] FAIL mid_m1_reset: got %0h expected 0", {m1ValidA, m1DataA}); end
        compared++; if ({checkDoneA, idOkA, tsOkA, irqA} !== 4'b0000) begin mismatched++; $display("[TB] FAIL mid_flags_reset: got %b expected 0000", {checkDoneA, idOkA, tsOkA, irqA}); end
        resetN = 1'b1;
        m1ReadA = 1'b0;
        #1;
        compared++; if (m1WaitA !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_wait_idle: got %b expected 0", m1WaitA); end
        step;
        compared++; if ({m1ValidA, checkDoneA} !== 2'b00) begin mismatched++; $display("[TB] FAIL mid_restart1: got %b expected 00", {m1ValidA, checkDoneA}); end
        step;
        compared++; if ({checkDoneA, idOkA, tsOkA, irqA} !== 4'b1110) begin mismatched++; $display("[TB] FAIL mid_restart2: got %b expected 1110", {checkDoneA, idOkA, tsOkA, irqA}); end
    endtask

    // n counts cycles from the first IDLE cycle; rechecks occupy cycles 8k and 8k+1 for k >= 1.
    task test_recheck;
        logic stall, prevGrant, expAddr;
        logic [31:0] prevData;
        idB = ID_GOOD; tsB = TS_GOOD;
        resetToIdle;
        m0ReadB = 1'b1; m0AddrB = 1'b0;
        prevGrant = 1'b0; prevData = 32'd0;
        for (int n = 0; n < 40; n++) begin
            if (n == 12) idB = 32'd30;
            #1;
            stall = (n >= 8) && ((n % 8) < 2);
            expAddr = stall && ((n % 8) == 1);
            compared++; if (m0WaitB !== stall) begin mismatched++; $display("[TB] FAIL rc_wait[%0d]: got %b expected %b", n, m0WaitB, stall); end
            compared++; if (sysidAddrB !== expAddr) begin mismatched++; $display("[TB] FAIL rc_addr[%0d]: got %b expected %b", n, sysidAddrB, expAddr); end
            compared++; if (m0ValidB !== prevGrant) begin mismatched++; $display("[TB] FAIL rc_valid[%0d]: got %b expected %b", n, m0ValidB, prevGrant); end
            if (prevGrant) begin
                compared++; if (m0DataB !== prevData) begin mismatched++; $display("[TB] FAIL rc_data[%0d]: got %0h expected %0h", n, m0DataB, prevData); end
            end
            compared++; if ({checkDoneB, idOkB, irqB} !== {1'b1, n < 17, n >= 18}) begin mismatched++; $display("[TB] FAIL rc_flags[%0d]: got %b expected %b", n, {checkDoneB, idOkB, irqB}, {1'b1, n < 17, n >= 18}); end
            prevGrant = !stall;
            prevData = idB;
            step;
        end
        compared++; if (tsOkB !== 1'b1) begin mismatched++; $display("[TB] FAIL rc_ts_ok: got %b expected 1", tsOkB); end
        m0ReadB = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset;
        test_id_mismatch;
        test_single_read;
        test_back_to_back;
        test_random;
        test_reset_mid_grant;
        test_recheck;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sysid_check_arbiter.md
Name: sysid_check_arbiter

Overview:
- Sequences and shares the 1-bit-address system-ID slave: word 0 = system ID, word 1 = build timestamp; readdata is combinational from address.
- After reset it reads both words and compares them against expected values, flagging any mismatch.
- It then arbitrates read access to the slave between two Avalon-MM read masters (m0, m1), round-robin.
- It optionally re-runs the check periodically.

Parameters:
- EXPECTED_ID, 29, value the slave must return at address 0.
- EXPECTED_TS, 1718188374, value the slave must return at address 1.
- RECHECK_PERIOD, 0, number of clock cycles between automatic rechecks; 0 disables recheck. Counter is 32 bits.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- sysid_address  out  1  address to the sysid slave
- sysid_readdata  in  32  combinational read data from the sysid slave
- m0_read  in  1  master 0 read request
- m0_address  in  1  master 0 word select
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  32  master 0 returned data
- m0_readdatavalid  out  1  master 0 data-valid pulse
- m1_read, m1_address, m1_waitrequest, m1_readdata, m1_readdatavalid: same as m0, for master 1
- irq_clear  in  1  clears mismatch_irq
- check_done  out  1  first check complete (sticky)
- id_ok  out  1  last ID compare passed
- ts_ok  out  1  last timestamp compare passed
- mismatch_irq  out  1  sticky mismatch interrupt

Behaviour:
- One clock; reset is synchronous and active-low, on port reset_n sampled at the clock edge.
- Reset values: m*_readdata = 0, m*_readdatavalid = 0, check_done = 0, id_ok = 0, ts_ok = 0, mismatch_irq = 0, recheck counter = 0, last_grant = m1 (so m0 wins the first tie), state = CHK_ID.
- FSM states: CHK_ID, CHK_TS, IDLE.
  - CHK_ID: sysid_address = 0; at the edge, id_ok <= (sysid_readdata == EXPECTED_ID); go to CHK_TS.
  - CHK_TS: sysid_address = 1; at the edge, ts_ok <= compare against EXPECTED_TS; check_done <= 1; mismatch_irq <= 1 if either compare failed (using this cycle's ts result and the registered id_ok); go to IDLE. Check latency from reset release = 2 cycles.
  - IDLE, no recheck pending: grant one requesting master.
    - Single requester: grant it.
    - Both requesting: grant the master that is not last_grant.
    - Granted master: sysid_address = its address; at the edge, its readdata <= sysid_readdata, its readdatavalid <= 1 for exactly 1 cycle; last_grant updates.
    - Read latency: accept cycle + 1. Back-to-back accepts every cycle are allowed.
  - IDLE, recheck pending: no grant; go to CHK_ID. Recheck has priority over masters.
- mX_waitrequest (combinational) = mX_read AND NOT (state == IDLE AND no recheck pending AND grant == X). It is 1 during reset if read is asserted. It is 0 when read is low.
- mX_readdata holds its value until the next accepted read for that master.
- Recheck (only when RECHECK_PERIOD > 0):
  - The counter runs from the first entry to IDLE and increments every cycle.
  - When it reaches RECHECK_PERIOD-1, it wraps to 0 and sets recheck pending.
  - Pending clears on entry to CHK_ID.
  - During a recheck, id_ok and ts_ok hold their old values until rewritten; check_done stays 1. Masters stall exactly 2 cycles.
- mismatch_irq is sticky; irq_clear clears it at the edge. If irq_clear and a new mismatch occur in the same cycle, set wins.
- Reset mid-operation:
  - All registers return to reset values at that edge.
  - No readdatavalid is issued for reads accepted in or after the reset cycle.
  - The check restarts at CHK_ID.
- Compares are full 32-bit equality. There is no other arithmetic besides the recheck counter.

Test Plan:
- Reset released, slave returns 29 / 1718188374 -> after 2 cycles check_done = 1, id_ok = 1, ts_ok = 1, mismatch_irq = 0; sysid_address sequence 0, 1.
- Slave returns 30 at address 0 -> id_ok = 0, ts_ok = 1, mismatch_irq = 1; pulse irq_clear -> mismatch_irq = 0 next cycle; irq_clear asserted with a simultaneous mismatch -> stays 1.
- In IDLE, m0 reads address 1 -> m0_waitrequest = 0 in the same cycle; next cycle m0_readdatavalid = 1 for 1 cycle with m0_readdata = 1718188374; m1 outputs unchanged.
- m0 and m1 both hold read for 6 cycles (addresses 0 and 1) -> grants m0, m1, m0, m1, m0, m1; each master gets 3 valid pulses with the correct data; the non-granted master sees waitrequest = 1.
- RECHECK_PERIOD = 8, m0 reading continuously, slave ID changed to 30 mid-run -> at each recheck m0_waitrequest is high for exactly 2 cycles, sysid_address goes 0 then 1, and id_ok falls / mismatch_irq rises after the first recheck following the change.
- reset_n low in the cycle m1 is granted -> next cycle all outputs are at reset values, no m1_readdatavalid; the check restarts and completes 2 cycles after release.
